// File: rtl/dma_bus_arbiter.sv
// Round-robin bus arbiter between the CPU and N_CH DMA channels: capped bursts,
// early termination, one-cycle bus turnaround and an optional CPU cycle-steal window.
module dma_bus_arbiter #(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 4,
  parameter int BURST_LEN = 12,
  parameter int CPU_SLOT  = 4
) (
  input  logic             Clk,
  input  logic             Reset_N,
  input  logic [N_CH-1:0]  br,
  input  logic [N_CH-1:0]  dma_end,
  input  logic             steal_mode,
  output logic [N_CH-1:0]  bg,
  output logic [2:0]       grant_id,
  output logic [CNT_W-1:0] burst_cnt,
  output logic             cpu_bus_ok,
  output logic             bus_busy
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, STEAL} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [7:0]       SLOT_LAST = 8'((CPU_SLOT > 0) ? CPU_SLOT - 1 : 0);
  localparam logic [2:0]       LAST_CH   = 3'(N_CH - 1);

  generate
    if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
      $error("dma_bus_arbiter: N_CH must be 1..8");
    end
    if (BURST_LEN < 1 || BURST_LEN > (1 << CNT_W)) begin : g_bad_burst_len
      $error("dma_bus_arbiter: BURST_LEN must be 1..2**CNT_W");
    end
    if (CPU_SLOT < 0 || CPU_SLOT > 255) begin : g_bad_cpu_slot
      $error("dma_bus_arbiter: CPU_SLOT must be 0..255");
    end
  endgenerate

  state_t     state;
  logic [2:0] last_grant;
  logic [7:0] slot_cnt;

  logic [2:0] sel;
  logic       sel_vld;
  logic       term;

  // Lowest requester above last_grant wins; otherwise wrap to the lowest requester overall.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int j = 0; j < N_CH; j++) begin
      if (!sel_vld && br[j] && (3'(j) > last_grant)) begin
        sel     = 3'(j);
        sel_vld = 1'b1;
      end
    end
    for (int j = 0; j < N_CH; j++) begin
      if (!sel_vld && br[j]) begin
        sel     = 3'(j);
        sel_vld = 1'b1;
      end
    end
  end

  // bg is one-hot during GRANT, so masking with it picks the granted channel's bits.
  always_comb begin
    term = (burst_cnt == CNT_LAST) || (|(dma_end & bg)) || !(|(br & bg));
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      state      <= IDLE;
      bg         <= '0;
      grant_id   <= '0;
      burst_cnt  <= '0;
      cpu_bus_ok <= 1'b1;
      bus_busy   <= 1'b0;
      last_grant <= LAST_CH;
      slot_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            bg         <= N_CH'(1) << sel;
            grant_id   <= sel;
            last_grant <= sel;
            burst_cnt  <= '0;
            cpu_bus_ok <= 1'b0;
            bus_busy   <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (term) begin
            bg        <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
            state     <= RELEASE;
          end else begin
            burst_cnt <= burst_cnt + CNT_W'(1);
          end
        end
        RELEASE: begin
          cpu_bus_ok <= 1'b1;
          bus_busy   <= 1'b0;
          slot_cnt   <= '0;
          if (steal_mode && (CPU_SLOT > 0)) begin
            state <= STEAL;
          end else begin
            state <= IDLE;
          end
        end
        STEAL: begin
          if (slot_cnt == SLOT_LAST) begin
            state <= IDLE;
          end else begin
            slot_cnt <= slot_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_bg_onehot: assert property (@(posedge Clk) disable iff (!Reset_N) $onehot0(bg));
  a_bg_cpu_excl: assert property (@(posedge Clk) disable iff (!Reset_N) !((|bg) && cpu_bus_ok));
  a_burst_cap: assert property (@(posedge Clk) disable iff (!Reset_N) burst_cnt <= CNT_LAST);

endmodule

// File: doc/dma_bus_arbiter.md
Name: dma_bus_arbiter

Overview:
- Multi-channel bus arbiter between the pipelined CPU and N_CH DMA engines sharing the data-memory bus.
- Replaces the single-channel BR/BG handshake and hard-coded 12-cycle burst counter in the CPU top level.
- Adds round-robin arbitration, a parametrised burst length, per-channel early termination, a mandatory bus-turnaround cycle and an optional cycle-steal mode that guarantees the CPU a bus window between bursts.

Parameters:
- N_CH, 2, number of DMA request channels (1..8).
- CNT_W, 4, width of the burst counter.
- BURST_LEN, 12, maximum bus cycles per grant (1..2^CNT_W).
- CPU_SLOT, 4, CPU-owned cycles forced after each burst in steal mode (0..255).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_N  input  1  asynchronous, active-low reset.
- br  input  N_CH  bus request per channel; level, held high while the channel wants the bus.
- dma_end  input  N_CH  per-channel end-of-transfer pulse; ends the burst early.
- steal_mode  input  1  0 = back-to-back bursts allowed; 1 = CPU_SLOT window after every burst. Sampled only in RELEASE.
- bg  output  N_CH  bus grant, one-hot or zero, registered.
- grant_id  output  3  index of the granted channel; valid while any bg bit is set, 0 otherwise.
- burst_cnt  output  CNT_W  cycles elapsed in the current grant.
- cpu_bus_ok  output  1  CPU may drive the data bus; when low, the CPU tri-states its d_* signals.
- bus_busy  output  1  high in GRANT or RELEASE.

Behaviour:
- Single clock domain on Clk. All state resets asynchronously on Reset_N low.
- Reset values: bg=0, grant_id=0, burst_cnt=0, cpu_bus_ok=1, bus_busy=0, state=IDLE, last_grant=N_CH-1, so channel 0 wins first.
- Reset mid-burst: bg drops immediately (asynchronous). Counters clear. Pending requests are re-arbitrated after reset releases, with channel 0 first.

States:
- IDLE
  - CPU owns the bus; cpu_bus_ok=1.
  - If any br bit is high, select the first requesting channel searching upward from last_grant+1 modulo N_CH.
  - On the next edge: bg[sel]=1, grant_id=sel, last_grant=sel, burst_cnt=0, state GRANT.
  - Latency from br rise to bg rise is exactly 1 cycle.
- GRANT
  - cpu_bus_ok=0, bus_busy=1.
  - burst_cnt increments by 1 each cycle.
  - Terminates on any of:
    - (a) burst_cnt==BURST_LEN-1,
    - (b) dma_end[grant_id]=1,
    - (c) br[grant_id]=0.
  - On termination, the next edge gives bg=0, burst_cnt=0, state RELEASE.
  - Simultaneous (a)/(b)/(c) cause a single termination.
  - dma_end or br activity on non-granted channels is ignored except for arbitration.
  - The grant lasts at most BURST_LEN cycles.
- RELEASE
  - Exactly 1 turnaround cycle: bg=0, cpu_bus_ok=0, bus_busy=1; nobody drives the bus.
  - Next state is STEAL if steal_mode=1 and CPU_SLOT>0, otherwise IDLE.
- STEAL
  - cpu_bus_ok=1, bus_busy=0.
  - An internal slot counter runs from 0 to CPU_SLOT-1; requests are ignored.
  - After CPU_SLOT cycles, state IDLE, and arbitration resumes the following cycle.

Rules:
- bg is never multi-hot.
- bg and cpu_bus_ok are never both high.
- A channel whose br drops before arbitration is not granted.
- No channel is granted twice in a row while another channel is requesting (round-robin fairness).
- The burst counter wraps only through the clear on termination, never arithmetically.
- BURST_LEN=1 gives a single-cycle grant.
- burst_cnt must not be compared with an out-of-range constant; BURST_LEN ≤ 2^CNT_W is asserted at elaboration.

Test Plan:
- Reset with br=0 -> bg=0, cpu_bus_ok=1. Raise br[0] at cycle 3 and hold it -> bg=01 at cycle 4, burst_cnt reaches 11, bg=00 at cycle 16, RELEASE at 16, IDLE at 17, regrant at 18.
- br=11 held, steal_mode=0 -> grants alternate ch0, ch1, ch0, each 12 cycles separated by one RELEASE plus one IDLE cycle; bg is never 11.
- br[1] only, dma_end[1] pulsed when burst_cnt=5 -> bg drops the next edge (6-cycle grant), then the 1-cycle turnaround.
- steal_mode=1, CPU_SLOT=4, br[0] held -> after each burst: 1 RELEASE cycle, 4 cycles with cpu_bus_ok=1 and bg=0, then IDLE, then a new grant.
- Reset_N pulsed low at burst_cnt=7 -> bg=0 and cpu_bus_ok=1 asynchronously. After release, channel 0 is granted first even if channel 1 was previously granted.
- br[0] drops at burst_cnt=3 with dma_end[0]=1 in the same cycle -> a single termination, and exactly one RELEASE cycle.
